// File: rtl/vd_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// vd_frame_sequencer_if
// Groups the data-path handshakes of the frame sequencer:
//   s_valid / s_data / s_ready        softbit input stream
//   buf_wr / buf_addr / buf_wdata     input-buffer write port
//   core_start / core_done            decoder frame_start / frame_done pulses
// Modports:
//   master - the sequencer (accepts the stream, drives buffer and core start)
//   slave  - the environment (stream source, buffer, decoder core)
// -----------------------------------------------------------------------------
interface vd_frame_sequencer_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              buf_wr;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              core_start;
  logic              core_done;

  modport master (
    input  s_valid, s_data, core_done,
    output s_ready, buf_wr, buf_addr, buf_wdata, core_start
  );

  modport slave (
    output s_valid, s_data, core_done,
    input  s_ready, buf_wr, buf_addr, buf_wdata, core_start
  );
endinterface

// File: rtl/vd_frame_sequencer.sv
// -----------------------------------------------------------------------------
// vd_frame_sequencer
// Runs a sequence of decoder frames: for each frame it loads frame_words
// softbits from the input stream into the input buffer (starting at base),
// waits GAP_CYC cycles, kicks the decoder core, waits for its frame_done
// (guarded by an optional watchdog) and settles SETTLE_CYC cycles.
// Ports:
//   clk_i, rst_sync_i         clock, synchronous active-high reset
//   start_i, abort_i          run request pulse (IDLE only) / run cancel
//   num_frames_i .. timeout_i run configuration, latched on start
//   bus (master)              stream in, buffer write, core start/done
//   busy_o, done_o            run in progress / end-of-run pulse
//   err_timeout_o             sticky watchdog error of the last run
//   frames_done_o             frames completed in the current/last run
// -----------------------------------------------------------------------------
module vd_frame_sequencer #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 12,
  parameter int FRM_W      = 8,
  parameter int TMO_W      = 20,
  parameter int GAP_CYC    = 10,
  parameter int SETTLE_CYC = 5
) (
  input  logic              clk_i,
  input  logic              rst_sync_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [FRM_W-1:0]  num_frames_i,
  input  logic [ADDR_W-1:0] frame_words_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [TMO_W-1:0]  timeout_i,
  vd_frame_sequencer_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o,
  output logic [FRM_W-1:0]  frames_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_KICK, S_WAIT, S_SETTLE
  } state_e;

  // GAP and SETTLE always last at least one cycle; they share one counter.
  localparam int GAP_LEN    = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int SETTLE_LEN = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CNT_MAX    = (GAP_LEN > SETTLE_LEN) ? GAP_LEN : SETTLE_LEN;
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic [FRM_W-1:0]  nf_q, nf_d;
  logic [ADDR_W-1:0] fw_q, fw_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [FRM_W-1:0]  frames_q, frames_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic load_rdy;
  logic beat;

  // Combinational outputs are forced low while reset is held, so a reset
  // arriving mid-LOAD never lets a beat through in the reset cycle.
  assign load_rdy = (state_q == S_LOAD) && !rst_sync_i;
  assign beat     = load_rdy && bus.s_valid;

  assign bus.s_ready    = load_rdy;
  assign bus.buf_wr     = beat;
  assign bus.buf_addr   = beat ? (base_q + idx_q) : '0;
  assign bus.buf_wdata  = beat ? bus.s_data : {DATA_W{1'b0}};
  assign bus.core_start = (state_q == S_KICK) && !rst_sync_i;
  assign busy_o         = (state_q != S_IDLE) && !rst_sync_i;
  assign done_o         = done_q;
  assign err_timeout_o  = err_q;
  assign frames_done_o  = frames_q;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    wd_d     = wd_q;
    nf_d     = nf_q;
    fw_d     = fw_q;
    base_d   = base_q;
    tmo_d    = tmo_q;
    frames_d = frames_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nf_d     = num_frames_i;
          fw_d     = frame_words_i;
          base_d   = base_addr_i;
          tmo_d    = timeout_i;
          frames_d = '0;
          err_d    = 1'b0;
          idx_d    = '0;
          if (num_frames_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = (frame_words_i == '0) ? S_GAP : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (idx_q == fw_q - ADDR_W'(1)) begin
            idx_d   = '0;
            state_d = S_GAP;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_KICK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_KICK: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + TMO_W'(1);
        // A done arriving on the expiry cycle still counts as success.
        if (bus.core_done) begin
          frames_d = frames_q + FRM_W'(1);
          state_d  = S_SETTLE;
        end else if ((tmo_q != '0) && (wd_q == tmo_q - TMO_W'(1))) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (frames_q < nf_q) begin
            state_d = (fw_q == '0) ? S_GAP : S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops the run silently; status of the run so far is preserved.
    if (abort_i) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      frames_d = frames_q;
      err_d    = err_q;
      done_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; the combinational block above uses
  // blocking assignments so later lines see the defaults set earlier.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      nf_q     <= '0;
      fw_q     <= '0;
      base_q   <= '0;
      tmo_q    <= '0;
      frames_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      nf_q     <= nf_d;
      fw_q     <= fw_d;
      base_q   <= base_d;
      tmo_q    <= tmo_d;
      frames_q <= frames_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/vd_frame_sequencer.md
VD_FRAME_SEQUENCER -- requirements
Module: vd_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, softbit word width.
REQ-002 SHALL have parameter ADDR_W, default 12, input-buffer address width.
REQ-003 SHALL have parameter FRM_W, default 8, frame-count width.
REQ-004 SHALL have parameter TMO_W, default 20, watchdog width.
REQ-005 SHALL have parameter GAP_CYC, default 10, cycles between load end and core start.
REQ-006 SHALL have parameter SETTLE_CYC, default 5, cycles after core done before next frame.
REQ-007 SHALL have clk_i  in  1  sole clock, all logic on its rising edge.
REQ-008 SHALL have rst_sync_i  in  1  reset, synchronous, active-high.
REQ-009 SHALL have start_i in 1 run request pulse; abort_i in 1 run cancel.
REQ-010 SHALL have num_frames_i in FRM_W, frame_words_i in ADDR_W, base_addr_i in ADDR_W, timeout_i in TMO_W (0 = watchdog off).
REQ-011 SHALL have s_valid_i in 1, s_data_i in DATA_W, s_ready_o out 1: softbit input stream.
REQ-012 SHALL have buf_wr_o out 1, buf_addr_o out ADDR_W, buf_wdata_o out DATA_W: input-buffer write port.
REQ-013 SHALL have core_start_o out 1 (pulse to decoder frame_start), core_done_i in 1 (decoder frame_done pulse).
REQ-014 SHALL have busy_o out 1, done_o out 1 (pulse), err_timeout_o out 1 (sticky), frames_done_o out FRM_W.

Function
REQ-015 SHALL implement states IDLE, LOAD, GAP, KICK, WAIT, SETTLE.
REQ-016 IDLE: start_i latches num_frames_i, frame_words_i, base_addr_i, timeout_i, clears frames_done_o and err_timeout_o, goes LOAD; start_i outside IDLE ignored.
REQ-017 Latched num_frames = 0: next cycle IDLE with done_o pulse, no writes, no core_start_o.
REQ-018 LOAD: s_ready_o = 1; beat accepted when s_valid_i & s_ready_o; same cycle buf_wr_o = 1, buf_wdata_o = s_data_i, buf_addr_o = (base + word index) mod 2^ADDR_W.
REQ-019 Word index restarts at 0 each frame; LOAD exits to GAP after accepting the last beat (index = frame_words-1); frame_words = 0 skips LOAD straight to GAP.
REQ-020 s_ready_o SHALL be 0 in every state except LOAD; no buffer write outside LOAD.
REQ-021 GAP: holds exactly GAP_CYC cycles (GAP_CYC = 0 means one cycle), then KICK.
REQ-022 KICK: core_start_o = 1 for exactly one cycle, watchdog counter cleared, then WAIT.
REQ-023 WAIT: watchdog increments each cycle; core_done_i -> frames_done_o + 1, go SETTLE.
REQ-024 WAIT with timeout_i != 0 and watchdog reaching timeout-1 without core_done_i: err_timeout_o set, done_o pulse, IDLE; remaining frames dropped.
REQ-025 core_done_i and watchdog expiry in same cycle: done wins, no error.
REQ-026 core_done_i outside WAIT SHALL be ignored.
REQ-027 SETTLE: holds SETTLE_CYC cycles (min one), then LOAD if frames_done_o < num_frames, else done_o pulse and IDLE.
REQ-028 abort_i (any state, priority over all but reset): IDLE next cycle, no done_o, err_timeout_o and frames_done_o hold values.
REQ-029 busy_o = 1 in every state except IDLE.
REQ-030 frames_done_o wraps mod 2^FRM_W (unreachable when num_frames <= 2^FRM_W - 1).

Reset
REQ-031 rst_sync_i high: state IDLE, all counters 0; s_ready_o, buf_wr_o, core_start_o, busy_o, done_o, err_timeout_o = 0; buf_addr_o, buf_wdata_o, frames_done_o = 0.
REQ-032 Reset mid-run SHALL abandon the run with no done_o pulse; priority over abort_i and start_i.

Verification
REQ-033 num_frames=2, frame_words=4, base=0xFFE, stream always valid -> writes to 0xFFE,0xFFF,0x000,0x001 per frame; core_start_o 10 cycles after last write; done_o after 2nd core_done_i + 5 cycles; frames_done_o=2.
REQ-034 Stream valid toggling every other cycle, frame_words=3 -> exactly 3 writes, addresses consecutive, no write when s_valid_i=0.
REQ-035 timeout=100, core_done_i never -> err_timeout_o=1 and done_o 100 cycles after core_start_o, busy_o=0 after.
REQ-036 num_frames=0 -> done_o one cycle after start_i, no buf_wr_o, no core_start_o.
REQ-037 abort_i asserted in WAIT, and rst_sync_i asserted in LOAD -> IDLE next cycle, busy_o=0, no done_o; start_i in WAIT ignored.
